// File: rtl/cpu_rst_gen_pkg.sv
// cpu_rst_gen_pkg: state encoding and counter sizing shared by the reset generator
package cpu_rst_gen_pkg;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_LOCK = 3'd1;
   localparam logic [2:0] SETTLE    = 3'd2;
   localparam logic [2:0] RUN       = 3'd3;
   localparam logic [2:0] LOST      = 3'd4;

   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cpu_rst_gen_if.sv
// cpu_rst_gen_if: lock flag in, CPU reset / run / tick / loss count out
interface cpu_rst_gen_if #(parameter int LOSS_W = 8);

   logic              locked;
   logic              cpu_rst_n;
   logic              run;
   logic              tick;
   logic [LOSS_W-1:0] loss_cnt;

   modport master (input locked, output cpu_rst_n, run, tick, loss_cnt);
   modport slave  (output locked, input cpu_rst_n, run, tick, loss_cnt);

endinterface

// File: rtl/cpu_rst_gen_sync_2ff.sv
// sync_2ff: two-stage synchronizer, clears asynchronously, q follows d two edges late
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic m;

   // shift d through two flops; both clear on reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, m} <= 2'b00;
      else        {q, m} <= {m, d};

endmodule

// File: rtl/cpu_rst_gen.sv
// cpu_rst_gen: holds the CPU in reset until cpuclk lock has settled, counts lock losses, makes a slow tick
module cpu_rst_gen
   import cpu_rst_gen_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int HOLD_CYCLES   = 8,
   parameter int TICK_DIV      = 100,
   parameter int LOSS_W        = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   cpu_rst_gen_if.master bus
);

   localparam int SW = cw(SETTLE_CYCLES);
   localparam int HW = cw(HOLD_CYCLES);
   localparam int DW = cw(TICK_DIV);

   logic              rst_i;
   logic              lock_s;
   logic [2:0]        st;
   logic [2:0]        nxt;
   logic [SW-1:0]     settle_cnt;
   logic [HW-1:0]     hold_cnt;
   logic [DW-1:0]     div_cnt;
   logic [LOSS_W-1:0] loss;
   logic              stay_run;

   sync_2ff u_rst_sync  (.clk(clk), .rst_n(rst_n), .d(1'b1),       .q(rst_i));
   sync_2ff u_lock_sync (.clk(clk), .rst_n(rst_n), .d(bus.locked), .q(lock_s));

   assign stay_run     = (st == RUN) && (nxt == RUN);
   assign bus.loss_cnt = loss;

   // next state: settle on steady lock, drop to LOST on lock loss, hold before retrying
   always_comb begin
      nxt = (st == IDLE)      ? WAIT_LOCK :
            (st == WAIT_LOCK) ? (lock_s ? SETTLE : WAIT_LOCK) :
            (st == SETTLE)    ? (!lock_s ? WAIT_LOCK :
                                 (settle_cnt == SW'(SETTLE_CYCLES - 1)) ? RUN : SETTLE) :
            (st == RUN)       ? (lock_s ? RUN : LOST) :
            (st == LOST)      ? ((hold_cnt == HW'(HOLD_CYCLES - 1)) ? WAIT_LOCK : LOST) :
                                IDLE;
   end

   // state, counters and registered outputs; outputs follow next state so they align with RUN
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) begin
         st            <= IDLE;
         settle_cnt    <= '0;
         hold_cnt      <= '0;
         div_cnt       <= '0;
         loss          <= '0;
         bus.cpu_rst_n <= 1'b0;
         bus.run       <= 1'b0;
         bus.tick      <= 1'b0;
      end else begin
         st            <= nxt;
         settle_cnt    <= (st == SETTLE && nxt == SETTLE) ? settle_cnt + 1'b1 : '0;
         hold_cnt      <= (st == LOST && nxt == LOST) ? hold_cnt + 1'b1 : '0;
         div_cnt       <= !stay_run ? '0 : (div_cnt == DW'(TICK_DIV - 1)) ? '0 : div_cnt + 1'b1;
         loss          <= (st == RUN && !lock_s && loss != '1) ? loss + 1'b1 : loss;
         bus.cpu_rst_n <= nxt == RUN;
         bus.run       <= nxt == RUN;
         bus.tick      <= stay_run && (div_cnt == DW'(TICK_DIV - 1));
      end

endmodule
